// File: rtl/mem_client_arbiter_if.sv
// MemIntf: val/rdy request/response channel shared by memory clients and servers.
// Parameter p_opaq_bits sets the width of the opaque tag field in both messages.
// Request message layout, MSB first: op[2:0], opaque, addr[31:0], strb[3:0], data[31:0].
// Response message layout, MSB first: op[2:0], opaque, test[1:0], len[1:0], data[31:0].
// Modports:
//   server - receives requests and returns responses (e.g. the arbiter's client-facing ports)
//   client - issues requests and accepts responses (e.g. the arbiter's memory-facing port)
interface MemIntf #(
   parameter int unsigned p_opaq_bits = 8
);
   localparam int unsigned lp_req_bits  = 3 + p_opaq_bits + 32 + 4 + 32;
   localparam int unsigned lp_resp_bits = 3 + p_opaq_bits + 2 + 2 + 32;

   logic                    req_val;
   logic                    req_rdy;
   logic [lp_req_bits-1:0]  req_msg;
   logic                    resp_val;
   logic                    resp_rdy;
   logic [lp_resp_bits-1:0] resp_msg;

   modport server (
      input  req_val, req_msg, resp_rdy,
      output req_rdy, resp_val, resp_msg
   );

   modport client (
      output req_val, req_msg, resp_rdy,
      input  req_rdy, resp_val, resp_msg
   );
endinterface

// File: rtl/mem_client_arbiter.sv
// mem_client_arbiter: shares one downstream memory port between two requesters.
// Requests are arbitrated round-robin (or fixed priority, c0 first, when the macro
// MEM_ARB_FIXED_PRIO_EN is defined) and forwarded combinationally. The grant is locked
// while a request is stalled downstream so val/msg stay stable. The winning requester's
// ID is pushed into an in-order tag FIFO; responses are routed to the requester at the
// FIFO head. Responses arriving with no outstanding tag are stalled.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   c0  - MemIntf.server, requester 0 (SPI loader client)
//   c1  - MemIntf.server, requester 1 (processor memory port)
//   mem - MemIntf.client, shared downstream memory
module mem_client_arbiter #(
   parameter int unsigned p_opaq_bits = 8,
   parameter int unsigned p_max_outst = 4
) (
   input  logic   clk,
   input  logic   rst,
   MemIntf.server c0,
   MemIntf.server c1,
   MemIntf.client mem
);
   localparam int unsigned lp_ptr_bits = $clog2(p_max_outst);
   localparam int unsigned lp_cnt_bits = lp_ptr_bits + 1;
   localparam int unsigned lp_req_bits = 3 + p_opaq_bits + 32 + 4 + 32;

   typedef enum logic {StFree, StLock} lock_state_t;

   lock_state_t            r_state;
   logic                   r_lock_id;
   logic [p_max_outst-1:0] r_tags;
   logic [lp_ptr_bits-1:0] r_wr_ptr;
   logic [lp_ptr_bits-1:0] r_rd_ptr;
   logic [lp_cnt_bits-1:0] r_count;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic                   r_last;  // 1: c1 was granted last
`endif

   logic                   w_full;
   logic                   w_empty;
   logic                   w_gnt;   // 0: c0, 1: c1
   logic [lp_req_bits-1:0] w_req_msg;
   logic                   w_req_val;
   logic                   w_gnt_rdy;
   logic                   w_push;
   logic                   w_head;
   logic                   w_resp_en;
   logic                   w_resp_rdy;
   logic                   w_pop;

   // Full/empty come from registered state only, so a same-cycle pop never frees a slot.
   assign w_full  = (r_count == lp_cnt_bits'(p_max_outst));
   assign w_empty = (r_count == '0);

   always_comb begin
      w_gnt = 1'b0;
      if (r_state == StLock) begin
         w_gnt = r_lock_id;
      end else if (c0.req_val && c1.req_val) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         w_gnt = 1'b0;
`else
         w_gnt = ~r_last;
`endif
      end else if (c1.req_val) begin
         w_gnt = 1'b1;
      end
   end

   assign w_req_msg = w_gnt ? c1.req_msg : c0.req_msg;
   assign w_req_val = (w_gnt ? c1.req_val : c0.req_val) && !w_full && !rst;
   assign w_gnt_rdy = mem.req_rdy && !w_full && !rst;
   assign w_push    = w_req_val && mem.req_rdy;

   assign mem.req_msg = w_req_msg;
   assign mem.req_val = w_req_val;
   assign c0.req_rdy  = !w_gnt && w_gnt_rdy;
   assign c1.req_rdy  = w_gnt && w_gnt_rdy;

   // Response side steers by the oldest outstanding tag.
   assign w_head     = r_tags[r_rd_ptr];
   assign w_resp_en  = !w_empty && !rst;
   assign w_resp_rdy = w_resp_en && (w_head ? c1.resp_rdy : c0.resp_rdy);
   assign w_pop      = mem.resp_val && w_resp_rdy;

   assign mem.resp_rdy = w_resp_rdy;
   assign c0.resp_val  = w_resp_en && !w_head && mem.resp_val;
   assign c1.resp_val  = w_resp_en && w_head && mem.resp_val;
   assign c0.resp_msg  = mem.resp_msg;
   assign c1.resp_msg  = mem.resp_msg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StFree;
         r_lock_id <= 1'b0;
         r_tags    <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         r_last    <= 1'b1;
`endif
      end else begin
         if (w_push) begin
            r_state          <= StFree;
            r_tags[r_wr_ptr] <= w_gnt;
            r_wr_ptr         <= r_wr_ptr + lp_ptr_bits'(1);
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last           <= w_gnt;
`endif
         end else if (w_req_val) begin
            // Stalled downstream: hold this grant until the handshake completes.
            r_state   <= StLock;
            r_lock_id <= w_gnt;
         end else begin
            r_state <= StFree;
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + lp_ptr_bits'(1);
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + lp_cnt_bits'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - lp_cnt_bits'(1);
         end
      end
   end
endmodule

// File: tb/tb_mem_client_arbiter.sv
// tb_mem_client_arbiter: directed, table-driven bench for mem_client_arbiter
// (default round-robin build). A vector table covers arbitration and grant locking with
// responses draining continuously; hand-written sequences cover FIFO full, in-order
// response routing, response backpressure and mid-transaction reset.
module tb_mem_client_arbiter;
   localparam int unsigned lp_req_bits  = 8 + 71;
   localparam int unsigned lp_resp_bits = 8 + 39;
   localparam logic [lp_req_bits-1:0]  lp_msg0 = 79'h00_0000_0000_0000_C0C0;
   localparam logic [lp_req_bits-1:0]  lp_msg1 = 79'h11_0000_0000_0000_C1C1;
   localparam logic [lp_resp_bits-1:0] lp_rmsg = 47'h1234_5678_9ABC;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   MemIntf #(.p_opaq_bits(8)) c0_if ();
   MemIntf #(.p_opaq_bits(8)) c1_if ();
   MemIntf #(.p_opaq_bits(8)) mem_if ();

   mem_client_arbiter #(
      .p_opaq_bits(8),
      .p_max_outst(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .c0 (c0_if),
      .c1 (c1_if),
      .mem(mem_if)
   );

   // Field order: inputs {c0v, c1v, mrdy}, expected {mval, gnt, c0rdy, c1rdy, c0rv, c1rv}
   typedef struct packed {
      logic c0v, c1v, mrdy;
      logic mval, gnt, c0r, c1r;
      logic c0rv, c1rv;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_req(input string nm, input logic mval, input logic gnt,
                          input logic c0r, input logic c1r);
      chk(nm, 128'({mem_if.req_val, mem_if.req_msg, c0_if.req_rdy, c1_if.req_rdy}),
          128'({mval, gnt ? lp_msg1 : lp_msg0, c0r, c1r}));
   endtask

   task automatic chk_resp(input string nm, input logic c0rv, input logic c1rv,
                           input logic mrr);
      chk(nm, 128'({c0_if.resp_val, c1_if.resp_val, mem_if.resp_rdy}),
          128'({c0rv, c1rv, mrr}));
   endtask

   task automatic drive(input logic c0v, input logic c1v, input logic mrdy, input logic rv,
                        input logic r0, input logic r1);
      @(negedge clk);
      c0_if.req_val   = c0v;
      c1_if.req_val   = c1v;
      mem_if.req_rdy  = mrdy;
      mem_if.resp_val = rv;
      c0_if.resp_rdy  = r0;
      c1_if.resp_rdy  = r1;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      c0_if.req_val   = 1'b0;
      c1_if.req_val   = 1'b0;
      mem_if.req_rdy  = 1'b0;
      mem_if.resp_val = 1'b0;
      c0_if.resp_rdy  = 1'b0;
      c1_if.resp_rdy  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = 9'b111_1010_00;  // tie after reset: c0
      vecs[1]  = 9'b111_1101_10;  // tie: alternate to c1
      vecs[2]  = 9'b111_1010_01;
      vecs[3]  = 9'b111_1101_10;
      vecs[4]  = 9'b010_1100_01;  // c1 alone, stalled: lock c1
      vecs[5]  = 9'b110_1100_00;  // c0 joins, grant stays c1
      vecs[6]  = 9'b110_1100_00;
      vecs[7]  = 9'b111_1101_00;  // c1 completes first
      vecs[8]  = 9'b101_1010_01;  // then c0
      vecs[9]  = 9'b111_1101_10;
      vecs[10] = 9'b001_0010_01;  // idle: msg from c0, mval low
      vecs[11] = 9'b000_0000_00;

      rst              = 1'b1;
      c0_if.req_msg    = lp_msg0;
      c1_if.req_msg    = lp_msg1;
      mem_if.resp_msg  = lp_rmsg;
      do_reset();

      // Reset state: nothing outstanding, stray response stalled.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_req("reset_req", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_resp("reset_resp", 1'b0, 1'b0, 1'b0);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].c0v, vecs[i].c1v, vecs[i].mrdy, 1'b1, 1'b1, 1'b1);
         chk_req($sformatf("vec%0d_req", i), vecs[i].mval, vecs[i].gnt, vecs[i].c0r,
                 vecs[i].c1r);
         chk_resp($sformatf("vec%0d_resp", i), vecs[i].c0rv, vecs[i].c1rv,
                  vecs[i].c0rv | vecs[i].c1rv);
      end

      // Fill FIFO with c0,c1,c1,c0; fifth request blocked.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("fill0", 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("fill1", 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("fill2", 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("fill3", 1'b1, 1'b0, 1'b1, 0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("full_block", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_resp("full_noresp", 1'b0, 1'b0, 1'b1);
      // Pop and pending request in the same cycle: no push yet.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_req("pop_full_req", 1'b0, 1'b1, 1'b0, 1'b0);
      chk_resp("pop_full_resp", 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("push_after_pop", 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("full_again", 1'b0, 1'b1, 1'b0, 1'b0);
      // Remaining tags in order: c1, c1, c0, c1.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_resp("drain0", 1'b0, 1'b1, 1'b1);
      chk("drain0_msg", 128'(c1_if.resp_msg), 128'(lp_rmsg));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_resp("drain1", 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_resp("drain2", 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_resp("drain3", 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_resp("drain_empty", 1'b0, 1'b0, 1'b0);

      // Response backpressure from c1 while it owns the head tag.
      do_reset();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_req("bp_push", 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_resp("bp_hold0", 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_resp("bp_hold1", 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_resp("bp_release", 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_resp("bp_empty", 1'b0, 1'b0, 1'b0);

      // Reset with two requests outstanding.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("rr_push1", 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      rst             = 1'b1;
      c0_if.req_val   = 1'b1;
      c1_if.req_val   = 1'b1;
      mem_if.resp_val = 1'b1;
      #1;
      chk_req("in_rst_req", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_resp("in_rst_resp", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst           = 1'b0;
      c0_if.req_val = 1'b0;
      c1_if.req_val = 1'b0;
      #1;
      chk_resp("post_rst_resp", 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_req("post_rst_tie", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_resp("post_rst_head", 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_req("post_rst_tie2", 1'b1, 1'b1, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_client_arbiter.md
MEM_CLIENT_ARBITER -- requirements
Module: mem_client_arbiter

Interface
REQ-001 SHALL have parameter p_opaq_bits, default 8, opaque field width of all three MemIntf ports.
REQ-002 SHALL have parameter p_max_outst, default 4 (power of 2, >=2), the maximum number of in-flight requests.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port c0  MemIntf.server  -  requester 0 (SPI loader client).
REQ-006 SHALL have port c1  MemIntf.server  -  requester 1 (processor memory port).
REQ-007 SHALL have port mem  MemIntf.client  -  shared downstream memory.

Function
REQ-008 SHALL forward the granted requester's req_msg to mem.req_msg unmodified (op, opaque, addr, strb, data), with zero-cycle combinational forwarding.
REQ-009 SHALL drive mem.req_val = granted requester's req_val AND NOT tag-FIFO full.
REQ-010 SHALL drive the granted requester's req_rdy = mem.req_rdy AND NOT full, and drive the non-granted requester's req_rdy = 0.
REQ-011 SHALL arbitrate round-robin when no grant is locked:
- only one requester valid: that requester wins;
- both valid: the requester not granted last wins.
REQ-012 SHALL lock the grant from the first cycle mem.req_val=1 without mem.req_rdy until the handshake completes, even if the other requester asserts val, so the downstream val/msg stay stable.
REQ-013 SHALL update the last-granted pointer only on a completed request handshake (mem.req_val & mem.req_rdy).
REQ-014 SHALL push the granted requester ID (1 bit) into a tag FIFO of depth p_max_outst on each request handshake; downstream memory returns responses in request order.
REQ-015 SHALL route mem.resp_msg to the requester at the FIFO head:
- that requester's resp_val = mem.resp_val;
- mem.resp_rdy = that requester's resp_rdy;
- the other requester's resp_val = 0.
REQ-016 SHALL pop the FIFO on each response handshake (mem.resp_val & mem.resp_rdy).
REQ-017 SHALL drive mem.resp_rdy = 0 and both requesters' resp_val = 0 while the FIFO is empty; stray responses stall and are never delivered.
REQ-018 SHALL, when the FIFO is full, block new requests even if a pop occurs in the same cycle (full is evaluated on registered state).
REQ-019 SHALL, on a simultaneous push and pop with the FIFO not full, leave the occupancy count unchanged and update both pointers.
REQ-020 SHALL wrap FIFO pointers modulo p_max_outst, using a count register of width $clog2(p_max_outst)+1.
REQ-021 SHALL present idle outputs with no X:
- mem.req_val=0 when neither requester is valid;
- mem.req_msg is then driven from c0.

Reset
REQ-022 SHALL, on rst, clear the FIFO (count=0, pointers=0), clear the grant lock, and set last-granted to c1 so c0 wins the first tie.
REQ-023 SHALL hold all val/rdy outputs at 0 in the cycle rst is asserted.
REQ-024 SHALL, on rst asserted mid-transaction, discard all outstanding tags; responses returning after reset stall per REQ-017.

Configuration
REQ-025 SHALL compile fixed-priority arbitration when macro MEM_ARB_FIXED_PRIO_EN is defined:
- c0 always wins ties and the last-granted pointer is unused;
- REQ-012 grant locking still applies.
REQ-026 SHALL use round-robin arbitration per REQ-011 when MEM_ARB_FIXED_PRIO_EN is undefined.

Verification
REQ-027 SHALL cover: c0 and c1 both valid continuously with mem.req_rdy=1 -> grants alternate c0,c1,c0,c1 (fixed-prio build: c0 every cycle, c1 never).
REQ-028 SHALL cover: c1 valid, mem.req_rdy=0 for 3 cycles, c0 raises val in cycle 2 -> mem.req_msg stays c1's for all 3 cycles, and c1 completes before c0.
REQ-029 SHALL cover:
- stimulus: 4 requests issued c0,c1,c1,c0 with mem.resp_val held 0;
- response: 5th request blocked (req_rdy=0);
- then: responses returned in order -> delivered to c0,c1,c1,c0 with the other requester's resp_val=0.
REQ-030 SHALL cover: full FIFO with a response pop and a pending request in the same cycle -> no push that cycle, push occurs next cycle, count returns to 4.
REQ-031 SHALL cover: c1 resp_rdy=0 while head tag=c1 -> mem.resp_rdy=0, and the response is held until c1 resp_rdy=1.
REQ-032 SHALL cover: rst asserted with 2 outstanding requests, then mem.resp_val=1 -> mem.resp_rdy=0, no requester sees resp_val, and the next c0/c1 tie grants c0.
